// File: rtl/tmds_channel_decoder_pkg.sv
// Shared definitions for the TMDS receive lane: control tokens, FSM state
// encodings and the decoded-word record passed from the word decoder.
package tmds_channel_decoder_pkg;

  // DVI control tokens, indexed by {C1,C0}; bit 0 is the first bit on the wire
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Alignment FSM states
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  // Highest legal bit offset into the 20-bit window
  localparam logic [3:0] MAX_OFFSET = 4'd9;

  // Result of decoding one aligned 10-bit word
  typedef struct packed {
    logic       is_token;
    logic       c1;
    logic       c0;
    logic [7:0] data;
  } tmds_dec_t;

  // Undo the transition-minimising stage: d[i] is recovered from q[i]^q[i-1],
  // inverted when the word was XNOR-coded (bit 8 clear).
  function automatic logic [7:0] tmds_unxor(input logic [7:0] q, input logic xor_mode);
    logic [7:0] d;
    d[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = xor_mode ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_channel_decoder_word_decode.sv
// Combinational decode of one aligned TMDS word into token flag, C1/C0 and
// pixel byte. Data bytes are only meaningful when is_token is clear.
module tmds_word_decode
  import tmds_channel_decoder_pkg::*;
(
  input  logic [9:0] word_i,
  output tmds_dec_t  dec_o
);

  logic [7:0] q;

  // Classify the word as control token or data and recover the byte
  always_comb begin
    dec_o = '0;
    q     = word_i[9] ? ~word_i[7:0] : word_i[7:0];
    case (word_i)
      TMDS_CTRL_00: begin dec_o.is_token = 1'b1; dec_o.c1 = 1'b0; dec_o.c0 = 1'b0; end
      TMDS_CTRL_01: begin dec_o.is_token = 1'b1; dec_o.c1 = 1'b0; dec_o.c0 = 1'b1; end
      TMDS_CTRL_10: begin dec_o.is_token = 1'b1; dec_o.c1 = 1'b1; dec_o.c0 = 1'b0; end
      TMDS_CTRL_11: begin dec_o.is_token = 1'b1; dec_o.c1 = 1'b1; dec_o.c0 = 1'b1; end
      default:      dec_o.data = tmds_unxor(q, word_i[8]);
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: recovers word alignment from control tokens by
// slipping a bit offset through a two-word window, then decodes each aligned
// word to pixel byte, C0/C1 and DE. Outputs are forced to zero until locked.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int C_lock_tokens   = 8,
  parameter int C_search_cycles = 2048,
  parameter int C_slip_wait     = 4
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] in_word,
  output logic [7:0] out_data,
  output logic       out_c0,
  output logic       out_c1,
  output logic       out_de,
  output logic       out_locked,
  output logic [3:0] out_bitslip
);

  // The timer doubles as the settle counter in WAIT, so size it for the larger
  localparam int TMR_MAX = (C_search_cycles > C_slip_wait) ? C_search_cycles : C_slip_wait;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int LW      = $clog2(C_lock_tokens + 1);

  localparam logic [TW-1:0] SEARCH_N = TW'(C_search_cycles);
  localparam logic [TW-1:0] WAIT_N   = TW'(C_slip_wait);
  localparam logic [LW-1:0] LOCK_N   = LW'(C_lock_tokens);

  logic [9:0]    prev_q;
  logic [9:0]    aligned_q;
  logic [19:0]   win_shift;
  logic [9:0]    aligned_d;

  logic [1:0]    state_q,  state_d;
  logic [3:0]    offset_q, offset_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [LW-1:0] tok_q,    tok_d;
  logic [TW-1:0] timer_inc;
  logic [LW-1:0] tok_inc;

  logic [7:0]    data_q, data_d;
  logic          c0_q,   c0_d;
  logic          c1_q,   c1_d;
  logic          de_q,   de_d;

  tmds_dec_t     dec;

  // Select the 10 bits starting at the current offset from {in_word, prev_word}
  always_comb begin
    win_shift = {in_word, prev_q} >> offset_q;
    aligned_d = win_shift[9:0];
  end

  tmds_word_decode u_word_decode (
    .word_i (aligned_q),
    .dec_o  (dec)
  );

  // Alignment FSM: count tokens to lock, slip the offset when none are seen
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    timer_d   = timer_q;
    tok_d     = tok_q;
    timer_inc = timer_q + TW'(1);
    tok_inc   = tok_q + LW'(1);
    case (state_q)
      ST_SEARCH: begin
        timer_d = timer_inc;
        tok_d   = dec.is_token ? tok_inc : '0;
        // Lock wins over a slip that expires in the same cycle
        if (dec.is_token && (tok_inc >= LOCK_N)) begin
          state_d = ST_LOCKED;
          timer_d = '0;
          tok_d   = '0;
        end else if (timer_inc >= SEARCH_N) begin
          state_d = ST_SLIP;
          timer_d = '0;
          tok_d   = '0;
        end
      end
      ST_SLIP: begin
        offset_d = (offset_q >= MAX_OFFSET) ? '0 : offset_q + 4'd1;
        timer_d  = '0;
        tok_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        if (timer_inc >= WAIT_N) begin
          state_d = ST_SEARCH;
          timer_d = '0;
          tok_d   = '0;
        end
      end
      ST_LOCKED: begin
        timer_d = dec.is_token ? '0 : timer_inc;
        if (!dec.is_token && (timer_inc >= SEARCH_N)) begin
          state_d = ST_SEARCH;
          timer_d = '0;
          tok_d   = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        timer_d = '0;
        tok_d   = '0;
      end
    endcase
  end

  // Output word: gated on the next state so outputs and out_locked move together
  always_comb begin
    data_d = '0;
    de_d   = 1'b0;
    c0_d   = 1'b0;
    c1_d   = 1'b0;
    if (state_d == ST_LOCKED) begin
      if (dec.is_token) begin
        c0_d = dec.c0;
        c1_d = dec.c1;
      end else begin
        de_d   = 1'b1;
        data_d = dec.data;
        c0_d   = c0_q;
        c1_d   = c1_q;
      end
    end
  end

  // Window, FSM and output registers with synchronous reset
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      prev_q    <= '0;
      aligned_q <= '0;
      state_q   <= ST_SEARCH;
      offset_q  <= '0;
      timer_q   <= '0;
      tok_q     <= '0;
      data_q    <= '0;
      de_q      <= 1'b0;
      c0_q      <= 1'b0;
      c1_q      <= 1'b0;
    end else begin
      prev_q    <= in_word;
      aligned_q <= aligned_d;
      state_q   <= state_d;
      offset_q  <= offset_d;
      timer_q   <= timer_d;
      tok_q     <= tok_d;
      data_q    <= data_d;
      de_q      <= de_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
    end
  end

  assign out_data    = data_q;
  assign out_de      = de_q;
  assign out_c0      = c0_q;
  assign out_c1      = c1_q;
  assign out_locked  = (state_q == ST_LOCKED);
  assign out_bitslip = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: a TMDS encoder model feeds a k-bit rotation
// shim; expected decoder outputs go through a scoreboard queue.
module tb_tmds_channel_decoder;

  localparam int LOCK_T = 8;
  localparam int SRCH_T = 2048;
  localparam int WAIT_T = 4;
  localparam int STEP_T = SRCH_T + 1 + WAIT_T;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] in_word   = '0;
  logic [7:0] out_data;
  logic       out_c0, out_c1, out_de, out_locked;
  logic [3:0] out_bitslip;

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_decoder #(
    .C_lock_tokens  (LOCK_T),
    .C_search_cycles(SRCH_T),
    .C_slip_wait    (WAIT_T)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_word    (in_word),
    .out_data   (out_data),
    .out_c0     (out_c0),
    .out_c1     (out_c1),
    .out_de     (out_de),
    .out_locked (out_locked),
    .out_bitslip(out_bitslip)
  );

  typedef struct {
    bit          chk;
    logic [10:0] exp;
    string       tag;
  } sb_t;

  sb_t        sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         disp     = 0;
  int         k        = 0;
  logic [9:0] prev_w   = '0;
  logic [1:0] last_c   = 2'b00;
  logic       s_locked;
  logic [3:0] s_slip;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ones8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // DVI encoder with running disparity
  function automatic logic [9:0] enc_data(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] r;
    int n1, n1q, n0q;
    n1 = ones8(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = ones8(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      r = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      r = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      r = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(~qm[8]) + n1q - n0q;
    end
    return r;
  endfunction

  // One pixel cycle: sample, score the word driven 3 cycles ago, drive next
  task automatic step(input logic [9:0] w, input bit chk, input logic [10:0] exp, input string tag);
    sb_t        it;
    logic [19:0] cat;
    @(negedge clk_pixel);
    s_locked = out_locked;
    s_slip   = out_bitslip;
    if (sb.size() >= 3) begin
      it = sb.pop_front();
      if (it.chk) check(it.tag, {out_de, out_c1, out_c0, out_data}, it.exp);
    end
    cat     = {w, prev_w} >> (10 - k);
    in_word = cat[9:0];
    prev_w  = w;
    it.chk = chk; it.exp = exp; it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic send_tok(input logic [1:0] c, input bit chk);
    disp   = 0;
    last_c = c;
    step(tok(c), chk, {1'b0, c, 8'h00}, "ctrl");
  endtask

  task automatic send_data(input logic [7:0] b, input bit chk);
    step(enc_data(b), chk, {1'b1, last_c, b}, "data");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    send_tok(2'b00, 1'b0);
    send_tok(2'b00, 1'b0);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_lock(input int maxc, input string tag);
    for (int i = 0; i < maxc; i++) begin
      send_tok(2'b00, 1'b0);
      if (s_locked) break;
    end
    check(tag, 32'(s_locked), 32'd1);
  endtask

  initial begin
    logic [3:0] last_slip;
    int         last_chg, n_chg;
    logic [7:0] fixed_b [4];
    fixed_b[0] = 8'h00; fixed_b[1] = 8'hFF; fixed_b[2] = 8'hA5; fixed_b[3] = 8'h3C;

    // Reset state
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send_tok(2'b00, 1'b0);
    check("rst_locked", 32'(out_locked), 32'd0);
    check("rst_slip", 32'(out_bitslip), 32'd0);
    check("rst_outs", {out_de, out_c1, out_c0, out_data}, 32'd0);

    // k=0: lock within 12 cycles, then steady blanking
    k = 0;
    reset = 1'b0;
    sb.delete();
    wait_lock(12, "lock_k0");
    check("slip_k0", 32'(s_slip), 32'd0);
    for (int i = 0; i < 200; i++) send_tok(2'b00, 1'b1);

    // k=7: offset walks one step per slip period, then holds
    do_reset();
    k = 7;
    last_slip = 4'd0; last_chg = 0; n_chg = 0;
    for (int i = 0; i < 8 * STEP_T + 100; i++) begin
      send_tok(2'b00, 1'b0);
      if (s_slip != last_slip) begin
        check("walk_step", 32'(s_slip), 32'(last_slip + 4'd1));
        if (n_chg > 0) check("walk_period", i - last_chg, STEP_T);
        last_chg  = i;
        last_slip = s_slip;
        n_chg++;
      end
      if (s_locked) break;
    end
    check("lock_k7", 32'(s_locked), 32'd1);
    check("n_steps_k7", n_chg, 7);
    for (int i = 0; i < 20; i++) send_tok(2'b00, 1'b0);
    check("hold_slip_k7", 32'(s_slip), 32'd7);
    check("hold_lock_k7", 32'(s_locked), 32'd1);

    // k=3: data bytes and control codes through the scoreboard
    do_reset();
    k = 3;
    wait_lock(3 * STEP_T + 100, "lock_k3");
    check("slip_k3", 32'(s_slip), 32'd3);
    for (int i = 0; i < 4; i++) send_tok(2'b00, 1'b1);
    for (int i = 0; i < 4; i++) send_data(fixed_b[i], 1'b1);
    send_tok(2'b01, 1'b1); send_tok(2'b01, 1'b1);
    send_tok(2'b10, 1'b1); send_tok(2'b10, 1'b1);
    send_tok(2'b11, 1'b1); send_tok(2'b11, 1'b1);
    for (int i = 0; i < 8; i++) send_data(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 6; i++) send_tok(2'b00, 1'b1);

    // Token starvation while locked: unlock after 2048 data words
    for (int j = 0; j < SRCH_T; j++) send_data(8'($urandom_range(0, 255)), 1'b0);
    check("starve_still_locked", 32'(s_locked), 32'd1);
    send_tok(2'b00, 1'b0);
    send_tok(2'b00, 1'b0);
    check("starve_locked_2049", 32'(s_locked), 32'd1);
    send_tok(2'b00, 1'b0);
    check("starve_unlock", 32'(s_locked), 32'd0);
    check("starve_slip", 32'(s_slip), 32'd3);
    wait_lock(20, "relock_k3");
    check("relock_slip", 32'(s_slip), 32'd3);

    // Reset while locked at offset 5
    do_reset();
    k = 5;
    wait_lock(5 * STEP_T + 100, "lock_k5");
    check("slip_k5", 32'(s_slip), 32'd5);
    for (int i = 0; i < 4; i++) send_data(8'h5A, 1'b0);
    check("de_before_rst", 32'(out_de), 32'd1);
    reset = 1'b1;
    send_data(8'h5A, 1'b0);
    reset = 1'b0;
    sb.delete();
    check("midrst_locked", 32'(s_locked), 32'd0);
    check("midrst_slip", 32'(s_slip), 32'd0);
    check("midrst_outs", {out_de, out_c1, out_c0, out_data}, 32'd0);
    k = 0;
    wait_lock(16, "relock_k0");
    check("relock_slip0", 32'(s_slip), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
